// File: rtl/pong_score_keeper.sv
// Score keeper for pong: detects goals once per frame, runs the serve countdown,
// and latches the winner until a fresh restart press starts a new game.
module pong_score_keeper #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int SCREEN_W     = 640,
    parameter int SQUARE_SIZE  = 16
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [9:0] square_xpos,
    input  logic       restart,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       ball_freeze,
    output logic       serve_req,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {
        SERVE_WAIT = 2'b00,
        PLAY       = 2'b01,
        SCORED     = 2'b10,
        GAME_OVER  = 2'b11
    } state_t;

    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [10:0] SQ_W       = 11'(SQUARE_SIZE);
    localparam logic [10:0] SCR_W      = 11'(SCREEN_W);

    state_t     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] score_p1_q, score_p1_d;
    logic [3:0] score_p2_q, score_p2_d;
    logic       ball_freeze_q, ball_freeze_d;
    logic       serve_req_q, serve_req_d;
    logic       serve_dir_q, serve_dir_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;
    logic       restart_prev_q, restart_prev_d;

    logic [10:0] right_edge;
    logic        goal_left;
    logic        goal_right;
    logic        restart_rise;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN) ? WIN : s + 4'd1;
    endfunction

    assign right_edge   = {1'b0, square_xpos} + SQ_W;
    assign goal_left    = (square_xpos == 10'd0);
    assign goal_right   = (right_edge >= SCR_W);
    assign restart_rise = restart & ~restart_prev_q;

    always_comb begin
        state_d        = state_q;
        frame_cnt_d    = frame_cnt_q;
        score_p1_d     = score_p1_q;
        score_p2_d     = score_p2_q;
        ball_freeze_d  = ball_freeze_q;
        serve_req_d    = 1'b0;
        serve_dir_d    = serve_dir_q;
        game_over_d    = game_over_q;
        winner_d       = winner_q;
        restart_prev_d = restart;

        case (state_q)
            SERVE_WAIT: begin
                ball_freeze_d = 1'b1;
                if (frame_tick) begin
                    if (frame_cnt_q == SERVE_LAST) begin
                        serve_req_d = 1'b1;
                        frame_cnt_d = 8'd0;
                        state_d     = PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            PLAY: begin
                ball_freeze_d = 1'b0;
                // Left goal takes priority when both edges are hit in one sample.
                if (frame_tick && goal_left) begin
                    score_p2_d    = sat_inc(score_p2_q);
                    serve_dir_d   = 1'b0;
                    ball_freeze_d = 1'b1;
                    state_d       = SCORED;
                end else if (frame_tick && goal_right) begin
                    score_p1_d    = sat_inc(score_p1_q);
                    serve_dir_d   = 1'b1;
                    ball_freeze_d = 1'b1;
                    state_d       = SCORED;
                end
            end
            SCORED: begin
                // serve_dir points at the conceding player, so its complement is the scorer.
                ball_freeze_d = 1'b1;
                if (!serve_dir_q && score_p2_q == WIN) begin
                    game_over_d = 1'b1;
                    winner_d    = 1'b1;
                    state_d     = GAME_OVER;
                end else if (serve_dir_q && score_p1_q == WIN) begin
                    game_over_d = 1'b1;
                    winner_d    = 1'b0;
                    state_d     = GAME_OVER;
                end else begin
                    frame_cnt_d = 8'd0;
                    state_d     = SERVE_WAIT;
                end
            end
            GAME_OVER: begin
                ball_freeze_d = 1'b1;
                if (restart_rise) begin
                    score_p1_d  = 4'd0;
                    score_p2_d  = 4'd0;
                    frame_cnt_d = 8'd0;
                    game_over_d = 1'b0;
                    serve_dir_d = ~winner_q;
                    state_d     = SERVE_WAIT;
                end
            end
            default: state_d = SERVE_WAIT;
        endcase
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_q        <= SERVE_WAIT;
            frame_cnt_q    <= 8'd0;
            score_p1_q     <= 4'd0;
            score_p2_q     <= 4'd0;
            ball_freeze_q  <= 1'b1;
            serve_req_q    <= 1'b0;
            serve_dir_q    <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
            restart_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            score_p1_q     <= score_p1_d;
            score_p2_q     <= score_p2_d;
            ball_freeze_q  <= ball_freeze_d;
            serve_req_q    <= serve_req_d;
            serve_dir_q    <= serve_dir_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            restart_prev_q <= restart_prev_d;
        end
    end

    assign score_p1    = score_p1_q;
    assign score_p2    = score_p2_q;
    assign ball_freeze = ball_freeze_q;
    assign serve_req   = serve_req_q;
    assign serve_dir   = serve_dir_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule
